// File: rtl/nes_bus_pkg.sv
// Shared NES CPU-bus constants and the sprite-DMA state encoding.
package nes_bus_pkg;

   localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;  // PPU OAMDATA
   localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;  // OAMDMA trigger register
   localparam int unsigned XFER_LEN      = 256;       // bytes per sprite DMA

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      GET,
      PUT
   } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA bus initiator: stalls the CPU and copies one 256-byte page to OAMDATA,
// alternating GET (read source byte) and PUT (write OAMDATA) CPU cycles.
module oam_dma
   import nes_bus_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cpu_ce,
   input  logic        dma_start,
   input  logic [7:0]  dma_page,
   input  logic [7:0]  bus_rdata,
   output logic        cpu_halt,
   output logic        dma_busy,
   output logic        dma_done,
   output logic [15:0] bus_addr,
   output logic [7:0]  bus_wdata,
   output logic        bus_rden,
   output logic        bus_wren
);

   localparam logic [7:0] IDX_LAST = 8'(XFER_LEN - 1);

   dma_state_t state_q, state_d;
   logic [7:0] page_q, page_d;
   logic [7:0] idx_q, idx_d;
   logic [7:0] data_q, data_d;
   logic       parity_q;
   logic       done_q, done_d;

   // State and datapath registers; parity tracks CPU cycle parity even while idle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         page_q   <= 8'h00;
         idx_q    <= 8'h00;
         data_q   <= 8'h00;
         parity_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         page_q   <= page_d;
         idx_q    <= idx_d;
         data_q   <= data_d;
         done_q   <= done_d;
         if (cpu_ce) begin
            parity_q <= ~parity_q;
         end
      end
   end

   // Next-state logic; every transition except the start strobe waits for a CPU cycle end.
   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      idx_d   = idx_q;
      data_d  = data_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A cpu_ce coinciding with the strobe is not the end of the dummy cycle.
            if (dma_start) begin
               page_d  = dma_page;
               idx_d   = 8'h00;
               state_d = HALT;
            end
         end
         HALT: begin
            // New parity after this ce is ~parity_q; reads must start on an even cycle.
            if (cpu_ce) begin
               state_d = parity_q ? GET : ALIGN;
            end
         end
         ALIGN: begin
            if (cpu_ce) begin
               state_d = GET;
            end
         end
         GET: begin
            if (cpu_ce) begin
               data_d  = bus_rdata;
               state_d = PUT;
            end
         end
         PUT: begin
            if (cpu_ce) begin
               if (idx_q == IDX_LAST) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  // idx wraps within the page; page itself never increments.
                  idx_d   = idx_q + 8'd1;
                  state_d = GET;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Bus and status outputs decode purely from registered state.
   always_comb begin
      cpu_halt  = (state_q != IDLE);
      dma_busy  = (state_q != IDLE);
      dma_done  = done_q;
      bus_addr  = 16'h0000;
      bus_wdata = 8'h00;
      bus_rden  = 1'b0;
      bus_wren  = 1'b0;
      unique case (state_q)
         GET: begin
            bus_addr = {page_q, idx_q};
            bus_rden = 1'b1;
         end
         PUT: begin
            bus_addr  = OAM_DATA_ADDR;
            bus_wdata = data_q;
            bus_wren  = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: RAM model, cpu_ce every third clk, per-scenario checks.
module tb_oam_dma;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cpu_ce;
   logic        dma_start;
   logic [7:0]  dma_page;
   logic [7:0]  bus_rdata;
   logic        cpu_halt;
   logic        dma_busy;
   logic        dma_done;
   logic [15:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic        bus_rden;
   logic        bus_wren;

   int n_checks = 0;
   int n_errors = 0;

   logic ce_en  = 1'b0;
   int   ce_cnt = 0;
   logic tb_par = 1'b0;

   int          halt_ce;
   int          dummy_ce;
   int          done_cnt;
   int          both_cnt;
   int          bad_waddr;
   logic [15:0] rd_q[$];
   logic [7:0]  wr_q[$];

   always #5 clk = ~clk;

   oam_dma dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cpu_ce    (cpu_ce),
      .dma_start (dma_start),
      .dma_page  (dma_page),
      .bus_rdata (bus_rdata),
      .cpu_halt  (cpu_halt),
      .dma_busy  (dma_busy),
      .dma_done  (dma_done),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rden  (bus_rden),
      .bus_wren  (bus_wren)
   );

   // RAM contents: $0200+i = i^A5; other pages mixed with (page-2) so pages differ.
   function automatic logic [7:0] mem(input logic [15:0] a);
      logic [7:0] hi;
      hi = a[15:8] - 8'h02;
      return a[7:0] ^ 8'hA5 ^ hi;
   endfunction

   function automatic int count_bad_rd(input logic [7:0] page);
      int bad = 0;
      for (int i = 0; i < rd_q.size(); i++) begin
         if (rd_q[i] !== {page, 8'(i)}) bad++;
      end
      return bad;
   endfunction

   function automatic int count_bad_wr(input logic [7:0] page);
      int bad = 0;
      for (int i = 0; i < wr_q.size(); i++) begin
         if (wr_q[i] !== mem({page, 8'(i)})) bad++;
      end
      return bad;
   endfunction

   // Observe bus activity on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (reset_n) begin
         if (cpu_ce && cpu_halt) halt_ce++;
         if (cpu_ce && cpu_halt && !bus_rden && !bus_wren) dummy_ce++;
         if (cpu_ce && bus_rden) rd_q.push_back(bus_addr);
         if (cpu_ce && bus_wren) begin
            wr_q.push_back(bus_wdata);
            if (bus_addr !== 16'h2004) bad_waddr++;
         end
         if (dma_done) done_cnt++;
         if (bus_rden && bus_wren) both_cnt++;
      end
   end

   task automatic clear_mon();
      halt_ce   = 0;
      dummy_ce  = 0;
      done_cnt  = 0;
      both_cnt  = 0;
      bad_waddr = 0;
      rd_q.delete();
      wr_q.delete();
   endtask

   // One clock; inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
      if (cpu_ce && reset_n) tb_par = ~tb_par;
      ce_cnt++;
      cpu_ce    = ce_en && (ce_cnt % 3 == 0);
      bus_rdata = bus_rden ? mem(bus_addr) : 8'h00;
   endtask

   // Strobe start on a clk whose cpu_ce and current parity match the request.
   task automatic start_dma(input logic [7:0] page, input logic want_ce, input logic want_par);
      int guard = 0;
      while (!(cpu_ce == want_ce && tb_par == want_par) && guard < 50) begin
         tick();
         guard++;
      end
      dma_start = 1'b1;
      dma_page  = page;
      tick();
      dma_start = 1'b0;
      dma_page  = 8'h00;
   endtask

   task automatic run_xfer();
      int guard = 0;
      while (done_cnt == 0 && guard < 4000) begin
         tick();
         guard++;
      end
      repeat (6) tick();
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      cpu_ce    = 1'b0;
      dma_start = 1'b0;
      dma_page  = 8'h00;
      bus_rdata = 8'h00;
      repeat (3) tick();
      n_checks++;
      if ({cpu_halt, dma_busy, dma_done, bus_rden, bus_wren} !== 5'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl got=%b exp=00000",
                  {cpu_halt, dma_busy, dma_done, bus_rden, bus_wren});
      end
      n_checks++;
      if ({bus_addr, bus_wdata} !== 24'h0) begin
         n_errors++;
         $display("FAIL reset_bus got=%h exp=000000", {bus_addr, bus_wdata});
      end
      reset_n = 1'b1;
      ce_en   = 1'b1;
      repeat (10) tick();
      n_checks++;
      if ({cpu_halt, dma_busy, bus_rden, bus_wren} !== 4'b0) begin
         n_errors++;
         $display("FAIL idle_after_reset got=%b exp=0000",
                  {cpu_halt, dma_busy, bus_rden, bus_wren});
      end
   endtask

   task automatic test_even();
      clear_mon();
      start_dma(8'h02, 1'b0, 1'b1);
      n_checks++;
      if (cpu_halt !== 1'b1) begin
         n_errors++;
         $display("FAIL even_halt_next_clk got=%b exp=1", cpu_halt);
      end
      run_xfer();
      n_checks++;
      if (halt_ce !== 513) begin
         n_errors++;
         $display("FAIL even_halt_len got=%0d exp=513", halt_ce);
      end
      n_checks++;
      if (dummy_ce !== 1) begin
         n_errors++;
         $display("FAIL even_no_align got=%0d exp=1", dummy_ce);
      end
      n_checks++;
      if (wr_q.size() !== 256 || count_bad_wr(8'h02) !== 0) begin
         n_errors++;
         $display("FAIL even_wdata got=%0d writes %0d bad exp=256 writes 0 bad",
                  wr_q.size(), count_bad_wr(8'h02));
      end
      n_checks++;
      if (wr_q.size() < 2 || wr_q[0] !== 8'hA5 || wr_q[1] !== 8'hA4) begin
         n_errors++;
         $display("FAIL even_first_bytes got=%0d entries exp=A5,A4 first", wr_q.size());
      end
      n_checks++;
      if (done_cnt !== 1 || bad_waddr !== 0 || both_cnt !== 0) begin
         n_errors++;
         $display("FAIL even_done_bus got=done %0d badaddr %0d both %0d exp=1 0 0",
                  done_cnt, bad_waddr, both_cnt);
      end
   endtask

   task automatic test_odd();
      clear_mon();
      start_dma(8'h02, 1'b0, 1'b0);
      run_xfer();
      n_checks++;
      if (halt_ce !== 514) begin
         n_errors++;
         $display("FAIL odd_halt_len got=%0d exp=514", halt_ce);
      end
      n_checks++;
      if (dummy_ce !== 2) begin
         n_errors++;
         $display("FAIL odd_align_once got=%0d exp=2", dummy_ce);
      end
      n_checks++;
      if (rd_q.size() !== 256 || count_bad_rd(8'h02) !== 0 || count_bad_wr(8'h02) !== 0) begin
         n_errors++;
         $display("FAIL odd_data got=%0d reads %0d bad exp=256 reads 0 bad",
                  rd_q.size(), count_bad_rd(8'h02));
      end
   endtask

   task automatic test_busy_start();
      int guard = 0;
      clear_mon();
      start_dma(8'h02, 1'b0, 1'b1);
      while (rd_q.size() < 10 && guard < 200) begin
         tick();
         guard++;
      end
      dma_start = 1'b1;
      dma_page  = 8'h03;
      tick();
      dma_start = 1'b0;
      dma_page  = 8'h00;
      run_xfer();
      n_checks++;
      if (rd_q.size() !== 256 || count_bad_rd(8'h02) !== 0) begin
         n_errors++;
         $display("FAIL busy_start_reads got=%0d reads %0d bad exp=256 reads 0 bad",
                  rd_q.size(), count_bad_rd(8'h02));
      end
      n_checks++;
      if (count_bad_wr(8'h02) !== 0 || done_cnt !== 1 || halt_ce !== 513) begin
         n_errors++;
         $display("FAIL busy_start_xfer got=bad %0d done %0d halt %0d exp=0 1 513",
                  count_bad_wr(8'h02), done_cnt, halt_ce);
      end
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      clear_mon();
      start_dma(8'h02, 1'b0, 1'b1);
      while (rd_q.size() < 100 && guard < 2000) begin
         tick();
         guard++;
      end
      n_checks++;
      if (cpu_halt !== 1'b1) begin
         n_errors++;
         $display("FAIL mid_busy_before_reset got=%b exp=1", cpu_halt);
      end
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({cpu_halt, dma_busy, bus_rden, bus_wren} !== 4'b0 || bus_addr !== 16'h0) begin
         n_errors++;
         $display("FAIL mid_async_reset got=%b addr %h exp=0000 addr 0000",
                  {cpu_halt, dma_busy, bus_rden, bus_wren}, bus_addr);
      end
      tb_par = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      clear_mon();
      start_dma(8'h02, 1'b0, 1'b1);
      run_xfer();
      n_checks++;
      if (rd_q.size() < 1 || rd_q[0] !== 16'h0200) begin
         n_errors++;
         $display("FAIL mid_restart_first got=%0d reads exp=first read 0200", rd_q.size());
      end
      n_checks++;
      if (rd_q.size() !== 256 || count_bad_wr(8'h02) !== 0 || halt_ce !== 513) begin
         n_errors++;
         $display("FAIL mid_restart_xfer got=%0d reads halt %0d exp=256 reads halt 513",
                  rd_q.size(), halt_ce);
      end
   endtask

   task automatic test_start_on_ce();
      clear_mon();
      start_dma(8'h02, 1'b1, 1'b0);
      run_xfer();
      n_checks++;
      if (halt_ce !== 513 || done_cnt !== 1) begin
         n_errors++;
         $display("FAIL ce_start_even got=halt %0d done %0d exp=513 1", halt_ce, done_cnt);
      end
      clear_mon();
      start_dma(8'h02, 1'b1, 1'b1);
      run_xfer();
      n_checks++;
      if (halt_ce !== 514 || dummy_ce !== 2) begin
         n_errors++;
         $display("FAIL ce_start_odd got=halt %0d dummy %0d exp=514 2", halt_ce, dummy_ce);
      end
   endtask

   task automatic test_page_ff();
      clear_mon();
      start_dma(8'hFF, 1'b0, 1'b1);
      run_xfer();
      n_checks++;
      if (rd_q.size() !== 256 || rd_q[255] !== 16'hFFFF) begin
         n_errors++;
         $display("FAIL ff_last_addr got=%0d reads exp=256 reads last FFFF", rd_q.size());
      end
      n_checks++;
      if (count_bad_rd(8'hFF) !== 0 || count_bad_wr(8'hFF) !== 0) begin
         n_errors++;
         $display("FAIL ff_wrap got=%0d bad reads %0d bad writes exp=0 0",
                  count_bad_rd(8'hFF), count_bad_wr(8'hFF));
      end
      n_checks++;
      if ({cpu_halt, dma_busy, bus_rden, bus_wren} !== 4'b0 || done_cnt !== 1) begin
         n_errors++;
         $display("FAIL ff_idle_after got=%b done %0d exp=0000 done 1",
                  {cpu_halt, dma_busy, bus_rden, bus_wren}, done_cnt);
      end
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_even();
      test_odd();
      test_busy_start();
      test_reset_mid();
      test_start_on_ce();
      test_page_ff();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
